stfq_rank_computer: RTL and testbench
=====================================

// Module: stfq_rank_computer
// PURPOSE
//  Start-Time Fair Queueing rank stage directly upstream of the PIFO flow scheduler.
//  - Accepts packet descriptors (flow, length, id) from the classifier.
//  - Computes rank = max(virtual_time, last_finish[flow]).
//  - Drives the scheduler's push_1/push_rank_1/push_value_1 lane.
//  - Tracks scheduler occupancy with a credit counter and back-pressures upstream before overflow.
// PARAMETERS
//  NUM_FLOWS   8   number of flows with finish-time state
//  FLOW_W      3   flow index width, = $clog2(NUM_FLOWS)
//  LEN_W       16  packet length width (bytes)
//  SCHED_DEPTH 10  scheduler capacity N; initial credit count
// PORTS
//  clk            in   1       clock
//  rst            in   1       asynchronous active-low reset
//  in_valid       in   1       descriptor valid
//  in_ready       out  1       descriptor accepted when in_valid && in_ready
//  in_flow        in   FLOW_W  flow index
//  in_len         in   LEN_W   packet length
//  in_id          in   32      packet id, forwarded as scheduler value
//  push           out  1       to scheduler push_1
//  push_rank      out  32      to scheduler push_rank_1
//  push_value     out  32      to scheduler push_value_1
//  deq_valid      in   1       scheduler pop_valid (one entry left scheduler)
//  deq_rank       in   32      rank of dequeued packet, carried back by the output stage
//  occupancy      out  $clog2(SCHED_DEPTH+1)  entries pushed and not yet dequeued
// BEHAVIOUR
//  Reset (rst=0, async):
//   - push=0, push_rank=0, push_value=0, occupancy=0
//   - virtual time V=0, all last_finish[f]=0
//   - in_ready=0 while rst=0; in_ready=1 in the first cycle after release
//  in_ready = (occupancy + push != SCHED_DEPTH); combinational, no dependence on in_valid.
//   - push is counted so the credit consumed by the registered push is already reserved.
//  Accept cycle (in_valid && in_ready):
//   - start = max(V, last_finish[in_flow]), where V includes any same-cycle deq update below.
//   - finish = start + in_len, 33-bit sum saturated to 32'hFFFF_FFFF.
//   - last_finish[in_flow] <= finish.
//  Push output: registered.
//   - Next cycle push=1 for exactly one cycle, push_rank=start, push_value=in_id.
//   - No accept: push=0; push_rank/push_value hold their last values.
//   - Latency: accept edge to push high is 1 cycle. Back-to-back accepts produce back-to-back pushes.
//   - Same-flow back-to-back accepts must use the just-written finish: write-through/bypass,
//     no stall bubble.
//  Virtual time:
//   - On deq_valid, V <= max(V, deq_rank). V is monotonic non-decreasing.
//   - A same-cycle accept uses max(V, deq_rank) as V.
//  Occupancy counter (state register; not a separate FSM):
//   - occupancy += push (registered pulse), -= deq_valid.
//   - Both in the same cycle: net unchanged.
//   - deq_valid at occupancy 0 (spurious) is ignored; no underflow.
//   - Increment never exceeds SCHED_DEPTH; a violation is an assertion failure.
//  Idle flush:
//   - Cycle where occupancy==0, push==0, no accept: all last_finish[f] <= V.
//   - Keeps finish state bounded; no rank regression.
//  Saturation: once V or any finish reaches 32'hFFFF_FFFF it sticks; ranks tie at max.
//   - The scheduler's FIFO-on-tie ordering then applies.
//  in_flow >= NUM_FLOWS: descriptor accepted with rank=V; no table write.
//  Reset mid-operation: all state cleared immediately.
//   - A pending push is dropped (push=0 at once).
//   - The scheduler is reset by the same rst.
// TESTING
//  1. Reset release; flow 2 len 100 at V=0
//     -> next cycle push=1, rank 0; flow 2 then len 50 -> rank 100.
//  2. Flows 0,1 interleaved, len 10 each, four pkts
//     -> ranks 0,0,10,10; same-flow back-to-back -> ranks 0,10 with no bubble.
//  3. deq_valid with deq_rank=500 while accepting flow 3 (last_finish 20) same cycle -> rank 500.
//  4. Fill: 10 accepts with no deq -> in_ready=0 after 10th accept.
//     Then deq_valid and in_valid high together -> exactly one accept; occupancy stays 10.
//  5. last_finish[0]=32'hFFFF_FFF0, len 64 -> finish saturates 32'hFFFF_FFFF; next flow-0 rank FFFF_FFFF.
//  6. Assert rst low the cycle after an accept -> push never asserts; occupancy=0.
//     Post-release first rank is 0.

Source files
------------

// File: rtl/stfq_rank_computer.sv
// stfq_rank_computer: Start-Time Fair Queueing rank stage in front of the PIFO scheduler.
// Computes rank = max(V, last_finish[flow]), drives the scheduler push lane one cycle
// after acceptance, and tracks scheduler occupancy so upstream stalls before overflow.
module stfq_rank_computer #(
    parameter int unsigned NUM_FLOWS   = 8,
    parameter int unsigned FLOW_W      = 3,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned SCHED_DEPTH = 10,
    localparam int unsigned OCC_W      = $clog2(SCHED_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [FLOW_W-1:0] in_flow,
    input  logic [LEN_W-1:0]  in_len,
    input  logic [31:0]       in_id,
    output logic              push,
    output logic [31:0]       push_rank,
    output logic [31:0]       push_value,
    input  logic              deq_valid,
    input  logic [31:0]       deq_rank,
    output logic [OCC_W-1:0]  occupancy
);

    logic [31:0]      vtime_q, vtime_d;
    logic [31:0]      last_finish_q [NUM_FLOWS];
    logic [31:0]      last_finish_d [NUM_FLOWS];
    logic             push_q, push_d;
    logic [31:0]      push_rank_q, push_rank_d;
    logic [31:0]      push_value_q, push_value_d;
    logic [OCC_W-1:0] occupancy_q, occupancy_d;

    logic [OCC_W:0]   occ_sum;
    logic             flow_ok;
    logic             accept;
    logic             deq_eff;
    logic [31:0]      v_eff;
    logic [31:0]      lf_rd;
    logic [31:0]      start;
    logic [32:0]      sum;
    logic [31:0]      finish;

    // Out-of-range flow indices only exist when NUM_FLOWS is not a power of two.
    if (NUM_FLOWS < (1 << FLOW_W)) begin : g_flow_chk
        assign flow_ok = (32'(in_flow) < NUM_FLOWS);
    end else begin : g_flow_all
        assign flow_ok = 1'b1;
    end

    // Credit check, effective virtual time and rank/finish arithmetic for this cycle.
    always_comb begin
        occ_sum  = {1'b0, occupancy_q} + (OCC_W + 1)'(push_q);
        in_ready = rst && (occ_sum != (OCC_W + 1)'(SCHED_DEPTH));
        accept   = in_valid && in_ready;
        v_eff    = (deq_valid && (deq_rank > vtime_q)) ? deq_rank : vtime_q;
        lf_rd    = flow_ok ? last_finish_q[in_flow] : '0;
        start    = (lf_rd > v_eff) ? lf_rd : v_eff;
        sum      = {1'b0, start} + 33'(in_len);
        finish   = sum[32] ? '1 : sum[31:0];
        deq_eff  = deq_valid && (occupancy_q != '0);
    end

    // Next-state: finish table write or idle flush, push lane, occupancy credit.
    // The table is written at the accept edge and read combinationally, so a
    // same-flow accept in the following cycle already sees the new finish.
    always_comb begin
        vtime_d       = v_eff;
        last_finish_d = last_finish_q;
        if (accept && flow_ok) begin
            last_finish_d[in_flow] = finish;
        end else if (!accept && !push_q && (occupancy_q == '0)) begin
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                last_finish_d[f] = v_eff;
            end
        end
        push_d       = accept;
        push_rank_d  = accept ? start : push_rank_q;
        push_value_d = accept ? in_id : push_value_q;
        occupancy_d  = occupancy_q + OCC_W'(push_q) - OCC_W'(deq_eff);
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vtime_q      <= '0;
            for (int unsigned f = 0; f < NUM_FLOWS; f++) begin
                last_finish_q[f] <= '0;
            end
            push_q       <= 1'b0;
            push_rank_q  <= '0;
            push_value_q <= '0;
            occupancy_q  <= '0;
        end else begin
            vtime_q       <= vtime_d;
            last_finish_q <= last_finish_d;
            push_q        <= push_d;
            push_rank_q   <= push_rank_d;
            push_value_q  <= push_value_d;
            occupancy_q   <= occupancy_d;
        end
    end

    assign push       = push_q;
    assign push_rank  = push_rank_q;
    assign push_value = push_value_q;
    assign occupancy  = occupancy_q;

    // Outstanding entries plus the in-flight push must never exceed scheduler capacity.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        occ_sum <= (OCC_W + 1)'(SCHED_DEPTH));

endmodule

// File: tb/tb_stfq_rank_computer.sv
// Self-checking bench for stfq_rank_computer: directed scenarios plus randomized
// traffic, compared every cycle against a behavioural STFQ model.
module tb_stfq_rank_computer;

    localparam int NF    = 8;
    localparam int DEPTH = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_flow;
    logic [15:0] in_len;
    logic [31:0] in_id;
    logic        push;
    logic [31:0] push_rank;
    logic [31:0] push_value;
    logic        deq_valid;
    logic [31:0] deq_rank;
    logic [3:0]  occupancy;

    stfq_rank_computer #(
        .NUM_FLOWS(NF),
        .FLOW_W(3),
        .LEN_W(16),
        .SCHED_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_flow(in_flow),
        .in_len(in_len),
        .in_id(in_id),
        .push(push),
        .push_rank(push_rank),
        .push_value(push_value),
        .deq_valid(deq_valid),
        .deq_rank(deq_rank),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    // Behavioural model state: what the DUT must hold after the next edge.
    longint unsigned m_v;
    longint unsigned m_lf [NF];
    bit              m_push;
    longint unsigned m_rank;
    longint unsigned m_val;
    int              m_occ;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        m_v = 0;
        for (int f = 0; f < NF; f++) m_lf[f] = 0;
        m_push = 0;
        m_rank = 0;
        m_val  = 0;
        m_occ  = 0;
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs after the edge.
    task automatic cyc(input bit v, input int fl, input int ln, input logic [31:0] id,
                       input bit dq, input logic [31:0] dr);
        longint unsigned nv, st, fin;
        bit rdy, acc;
        int nocc;
        in_valid  = v;
        in_flow   = fl[2:0];
        in_len    = ln[15:0];
        in_id     = id;
        deq_valid = dq;
        deq_rank  = dr;
        rdy = (m_occ + (m_push ? 1 : 0)) != DEPTH;
        #1;
        chk("in_ready", {63'd0, in_ready}, {63'd0, rdy});
        nv  = (dq && dr > m_v) ? dr : m_v;
        acc = v && rdy;
        st  = 0;
        if (acc) begin
            st  = (m_lf[fl] > nv) ? m_lf[fl] : nv;
            fin = st + ln;
            if (fin > 64'hFFFF_FFFF) fin = 64'hFFFF_FFFF;
            m_lf[fl] = fin;
        end else if (m_occ == 0 && !m_push) begin
            for (int f = 0; f < NF; f++) m_lf[f] = nv;
        end
        nocc = m_occ + (m_push ? 1 : 0) - ((dq && m_occ > 0) ? 1 : 0);
        m_push = acc;
        if (acc) begin
            m_rank = st;
            m_val  = id;
        end
        m_occ = nocc;
        m_v   = nv;
        @(posedge clk);
        #1;
        chk("push", {63'd0, push}, {63'd0, m_push});
        chk("push_rank", {32'd0, push_rank}, m_rank);
        chk("push_value", {32'd0, push_value}, m_val);
        chk("occupancy", {60'd0, occupancy}, m_occ);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (m_occ > 0 || m_push); i++) cyc(0, 0, 0, 0, 1, 0);
        chk("drain_empty", {60'd0, occupancy}, 64'd0);
    endtask

    initial begin
        int npush;
        rst = 1'b0;
        in_valid = 0; in_flow = 0; in_len = 0; in_id = 0; deq_valid = 0; deq_rank = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_push", {63'd0, push}, 64'd0);
        chk("rst_rank", {32'd0, push_rank}, 64'd0);
        chk("rst_value", {32'd0, push_value}, 64'd0);
        chk("rst_occ", {60'd0, occupancy}, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready", {63'd0, in_ready}, 64'd1);

        // 1: flow 2 len 100 then len 50
        cyc(1, 2, 100, 32'hA001, 0, 0);
        chk("t1_rank0", {32'd0, push_rank}, 64'd0);
        chk("t1_push", {63'd0, push}, 64'd1);
        cyc(1, 2, 50, 32'hA002, 0, 0);
        chk("t1_rank100", {32'd0, push_rank}, 64'd100);

        // 2: interleaved flows 0,1 then same-flow back-to-back
        cyc(1, 0, 10, 32'hB000, 0, 0); chk("t2_r0", {32'd0, push_rank}, 64'd0);
        cyc(1, 1, 10, 32'hB001, 0, 0); chk("t2_r1", {32'd0, push_rank}, 64'd0);
        cyc(1, 0, 10, 32'hB002, 0, 0); chk("t2_r2", {32'd0, push_rank}, 64'd10);
        cyc(1, 1, 10, 32'hB003, 0, 0); chk("t2_r3", {32'd0, push_rank}, 64'd10);
        cyc(1, 4, 10, 32'hB004, 0, 0); chk("t2_b2b0", {32'd0, push_rank}, 64'd0);
        cyc(1, 4, 10, 32'hB005, 0, 0); chk("t2_b2b1", {32'd0, push_rank}, 64'd10);
        chk("t2_nobubble", {63'd0, push}, 64'd1);
        drain();

        // 3: same-cycle dequeue raises V above the flow's finish
        cyc(1, 3, 20, 32'hC000, 0, 0);
        cyc(1, 3, 5, 32'hC001, 1, 500);
        chk("t3_rank500", {32'd0, push_rank}, 64'd500);
        drain();

        // 4: fill the scheduler, then one dequeue admits exactly one packet
        for (int i = 0; i < DEPTH; i++) cyc(1, i % NF, 8, 32'hD000 + i, 0, 0);
        chk("t4_full_ready", {63'd0, in_ready}, 64'd0);
        cyc(0, 0, 0, 0, 0, 0);
        chk("t4_occ10", {60'd0, occupancy}, 64'd10);
        npush = 0;
        cyc(1, 5, 8, 32'hD100, 1, 0); npush += push;
        for (int i = 0; i < 3; i++) begin
            cyc(1, 5, 8, 32'hD101 + i, 0, 0);
            npush += push;
        end
        chk("t4_one_accept", npush, 64'd1);
        chk("t4_occ_stays", {60'd0, occupancy}, 64'd10);
        drain();

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit v, dq;
            int ln;
            v  = ($urandom_range(0, 9) < 7);
            dq = (m_occ > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
            ln = ($urandom_range(0, 31) == 0) ? 65535 : int'($urandom_range(0, 1000));
            cyc(v, int'($urandom_range(0, NF - 1)), ln, $urandom,
                dq, 32'(m_v) + 32'($urandom_range(0, 300)) - 32'd50);
        end
        drain();

        // 5: saturation of finish time
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFB0);
        cyc(1, 0, 64, 32'hE000, 0, 0);
        chk("t5_rank_b0", {32'd0, push_rank}, 64'hFFFF_FFB0);
        cyc(1, 0, 64, 32'hE001, 0, 0);
        chk("t5_rank_f0", {32'd0, push_rank}, 64'hFFFF_FFF0);
        cyc(1, 0, 64, 32'hE002, 0, 0);
        chk("t5_rank_sat", {32'd0, push_rank}, 64'hFFFF_FFFF);

        // 6: reset arrives before an accepted descriptor is registered
        in_valid = 1; in_flow = 2; in_len = 30; in_id = 32'hF000; deq_valid = 0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("t6_push_now", {63'd0, push}, 64'd0);
        chk("t6_occ_now", {60'd0, occupancy}, 64'd0);
        chk("t6_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("t6_push_held", {63'd0, push}, 64'd0);
        end
        in_valid = 0;
        rst = 1'b1;
        cyc(1, 2, 30, 32'hF001, 0, 0);
        chk("t6_post_rank0", {32'd0, push_rank}, 64'd0);
        chk("t6_post_push", {63'd0, push}, 64'd1);
        cyc(0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d", passed, total);
        $fatal(1);
    end

endmodule
